// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state set and bit-period helper.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   function automatic int uart_div(input int freq, input int baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input; reset level selectable.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic d_i,
   output logic q_o
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= d_i;
         r_sync <= r_meta;
      end
   end

   assign q_o = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, one-byte holding register,
// frame-error and overrun pulses.
//
// state | meaning
// IDLE  | line idle; wait for low while armed (armed once line seen high)
// START | half bit delay, confirm start bit still low
// DATA  | sample 8 data bits LSB first, one per bit period
// STOP  | sample stop bit; deliver byte or flag frame error
module uart_rx
   import uart_pkg::*;
#(
   parameter int FREQ = 27_000_000,
   parameter int BAUD = 115200
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       overrun_o
);

   localparam int DIV = uart_div(FREQ, BAUD);
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] C_FULL = CW'(DIV - 1);
   localparam logic [CW-1:0] C_HALF = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] C_ONE  = CW'(1);

   generate
      if (DIV < 4) begin : g_div_chk
         $error("uart_rx: FREQ/BAUD must be at least 4");
      end
   endgenerate

   logic          w_rx_s;
   uart_state_e   r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_idx;
   logic [7:0]    r_shift;
   logic          r_armed;
   logic          r_deliver;
   logic          r_frame_err;
   logic [7:0]    r_data;
   logic          r_valid;
   logic          r_overrun;

   sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .d_i    (rx_i),
      .q_o    (w_rx_s)
   );

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_idx       <= '0;
         r_shift     <= '0;
         r_armed     <= 1'b0;
         r_deliver   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_deliver   <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            IDLE: begin
               // Disarmed after a frame error so a held break cannot retrigger.
               if (w_rx_s) begin
                  r_armed <= 1'b1;
               end else if (r_armed) begin
                  r_state <= START;
                  r_cnt   <= C_HALF;
               end
            end
            START: begin
               if (r_cnt == '0) begin
                  if (!w_rx_s) begin
                     r_state <= DATA;
                     r_cnt   <= C_FULL;
                     r_idx   <= '0;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - C_ONE;
               end
            end
            DATA: begin
               if (r_cnt == '0) begin
                  r_shift[r_idx] <= w_rx_s;
                  r_cnt          <= C_FULL;
                  if (r_idx == 3'd7) begin
                     r_state <= STOP;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt - C_ONE;
               end
            end
            STOP: begin
               if (r_cnt == '0) begin
                  r_state <= IDLE;
                  if (w_rx_s) begin
                     r_deliver <= 1'b1;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_armed     <= 1'b0;
                  end
               end else begin
                  r_cnt <= r_cnt - C_ONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Holding register: a delivery may replace a byte only if it is being consumed.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_data    <= 8'h00;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (r_deliver) begin
            if (!r_valid || ready_i) begin
               r_data  <= r_shift;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data_o      = r_data;
   assign valid_o     = r_valid;
   assign frame_err_o = r_frame_err;
   assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV=10: serial frames driven from tasks,
// expectations from the sent bytes and the bit-period arithmetic.
module tb_uart_rx;

   localparam int FREQ = 1_000_000;
   localparam int BAUD = 100_000;
   localparam int DIV  = FREQ / BAUD;
   localparam int LAT  = 3 + DIV / 2 + 9 * DIV;
   localparam int FRM  = 10 * DIV;

   logic       clk_i   = 1'b0;
   logic       rstn_i  = 1'b0;
   logic       rx_i    = 1'b1;
   logic       ready_i = 1'b0;
   logic [7:0] data_o;
   logic       valid_o;
   logic       frame_err_o;
   logic       overrun_o;

   int n_cmp = 0;
   int n_bad = 0;
   int pos_cnt = 0;

   uart_rx #(.FREQ(FREQ), .BAUD(BAUD)) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .rx_i        (rx_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .frame_err_o (frame_err_o),
      .overrun_o   (overrun_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) pos_cnt++;

   // Event monitor, sampled just after the falling edge.
   int         rise_cnt = 0;
   int         rise_edge = 0;
   logic [7:0] rise_data = 8'h00;
   int         fe_cnt = 0;
   int         ov_cnt = 0;
   int         v_width = 0;
   int         last_width = 0;
   logic       v_prev = 1'b0;
   logic [7:0] hs_q[$];

   always @(negedge clk_i) begin
      #1;
      if (valid_o && !v_prev) begin
         rise_cnt++;
         rise_edge = pos_cnt;
         rise_data = data_o;
      end
      if (valid_o) v_width++;
      else if (v_prev) begin
         last_width = v_width;
         v_width = 0;
      end
      if (frame_err_o) fe_cnt++;
      if (overrun_o) ov_cnt++;
      if (valid_o && ready_i) hs_q.push_back(data_o);
      v_prev = valid_o;
   end

   // Must be called at a falling edge; returns at a falling edge with the line idle.
   task automatic send_frame(input logic [7:0] b, input logic stop, output int start_edge);
      start_edge = pos_cnt + 1;
      rx_i = 1'b0;
      repeat (DIV) @(negedge clk_i);
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         repeat (DIV) @(negedge clk_i);
      end
      rx_i = stop;
      repeat (DIV) @(negedge clk_i);
      rx_i = 1'b1;
   endtask

   task automatic test_reset();
      rstn_i = 1'b0;
      repeat (3) @(negedge clk_i);
      #2;
      n_cmp++; if (data_o !== 8'h00) begin n_bad++; $display("FAIL rst_data: got %h want 00", data_o); end
      n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", valid_o); end
      n_cmp++; if (frame_err_o !== 1'b0) begin n_bad++; $display("FAIL rst_ferr: got %b want 0", frame_err_o); end
      n_cmp++; if (overrun_o !== 1'b0) begin n_bad++; $display("FAIL rst_ovr: got %b want 0", overrun_o); end
      @(negedge clk_i);
      rstn_i = 1'b1;
      repeat (DIV) @(negedge clk_i);
      #2;
      n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL idle_valid: got %b want 0", valid_o); end
      n_cmp++; if (fe_cnt !== 0) begin n_bad++; $display("FAIL idle_ferr: got %0d want 0", fe_cnt); end
      @(negedge clk_i);
   endtask

   task automatic test_basic();
      int s, rc0, fe0, ov0;
      ready_i = 1'b1;
      rc0 = rise_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(8'hA5, 1'b1, s);
      repeat (3) @(negedge clk_i);
      #2;
      n_cmp++; if (rise_cnt - rc0 !== 1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", rise_cnt - rc0); end
      n_cmp++; if (rise_edge - s !== LAT) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", rise_edge - s, LAT); end
      n_cmp++; if (rise_data !== 8'hA5) begin n_bad++; $display("FAIL basic_data: got %h want a5", rise_data); end
      n_cmp++; if (last_width !== 1) begin n_bad++; $display("FAIL basic_width: got %0d want 1", last_width); end
      n_cmp++; if ((fe_cnt - fe0) + (ov_cnt - ov0) !== 0) begin n_bad++; $display("FAIL basic_flags: got %0d want 0", (fe_cnt - fe0) + (ov_cnt - ov0)); end
      @(negedge clk_i);
   endtask

   task automatic test_overrun();
      int s, rc0, ov0, fe0;
      ready_i = 1'b0;
      rc0 = rise_cnt; ov0 = ov_cnt; fe0 = fe_cnt;
      send_frame(8'h3C, 1'b1, s);
      send_frame(8'hC3, 1'b1, s);
      repeat (3) @(negedge clk_i);
      #2;
      n_cmp++; if (data_o !== 8'h3C) begin n_bad++; $display("FAIL ovr_data: got %h want 3c", data_o); end
      n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL ovr_valid: got %b want 1", valid_o); end
      n_cmp++; if (ov_cnt - ov0 !== 1) begin n_bad++; $display("FAIL ovr_pulses: got %0d want 1", ov_cnt - ov0); end
      n_cmp++; if (rise_cnt - rc0 !== 1 || fe_cnt - fe0 !== 0) begin n_bad++; $display("FAIL ovr_events: rises %0d ferr %0d want 1 0", rise_cnt - rc0, fe_cnt - fe0); end
      @(negedge clk_i);
      ready_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;
      #2;
      n_cmp++; if (valid_o !== 1'b0 || hs_q.size() == 0 || hs_q[$] !== 8'h3C) begin n_bad++; $display("FAIL ovr_consume: valid %b want 0, byte want 3c", valid_o); end
      @(negedge clk_i);
   endtask

   task automatic test_ready_coincide();
      int s1, sa, sb, ov0, hs0, target;
      ready_i = 1'b0;
      ov0 = ov_cnt; hs0 = hs_q.size();
      s1 = pos_cnt + 1;
      target = s1 + FRM + LAT - 1;
      fork
         begin
            send_frame(8'h6B, 1'b1, sa);
            send_frame(8'h94, 1'b1, sb);
         end
         begin
            for (int k = 0; k < 4 * FRM && pos_cnt != target; k++) @(negedge clk_i);
            ready_i = 1'b1;
            @(negedge clk_i);
            ready_i = 1'b0;
         end
      join
      repeat (3) @(negedge clk_i);
      #2;
      n_cmp++; if (data_o !== 8'h94) begin n_bad++; $display("FAIL coin_data: got %h want 94", data_o); end
      n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL coin_valid: got %b want 1", valid_o); end
      n_cmp++; if (ov_cnt - ov0 !== 0) begin n_bad++; $display("FAIL coin_overrun: got %0d want 0", ov_cnt - ov0); end
      n_cmp++; if (hs_q.size() - hs0 !== 1 || hs_q[$] !== 8'h6B) begin n_bad++; $display("FAIL coin_first: got %0d bytes want 1 of 6b", hs_q.size() - hs0); end
      @(negedge clk_i);
      ready_i = 1'b1;
      @(negedge clk_i);
      ready_i = 1'b0;
      #2;
      n_cmp++; if (valid_o !== 1'b0 || hs_q[$] !== 8'h94) begin n_bad++; $display("FAIL coin_consume: valid %b last %h want 0 94", valid_o, hs_q[$]); end
      @(negedge clk_i);
   endtask

   task automatic test_frame_err();
      int s, rc0, fe0;
      ready_i = 1'b1;
      rc0 = rise_cnt; fe0 = fe_cnt;
      send_frame(8'h55, 1'b0, s);
      rx_i = 1'b0;
      repeat (12 * DIV) @(negedge clk_i);
      rx_i = 1'b1;
      repeat (2 * DIV) @(negedge clk_i);
      #2;
      n_cmp++; if (fe_cnt - fe0 !== 1) begin n_bad++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - fe0); end
      n_cmp++; if (rise_cnt - rc0 !== 0) begin n_bad++; $display("FAIL ferr_valid: got %0d rises want 0", rise_cnt - rc0); end
      @(negedge clk_i);
      send_frame(8'h12, 1'b1, s);
      repeat (3) @(negedge clk_i);
      #2;
      n_cmp++; if (rise_cnt - rc0 !== 1 || rise_data !== 8'h12) begin n_bad++; $display("FAIL ferr_next: rises %0d data %h want 1 12", rise_cnt - rc0, rise_data); end
      n_cmp++; if (rise_edge - s !== LAT) begin n_bad++; $display("FAIL ferr_latency: got %0d want %0d", rise_edge - s, LAT); end
      @(negedge clk_i);
   endtask

   task automatic test_glitch();
      int s, rc0, fe0;
      ready_i = 1'b1;
      rc0 = rise_cnt; fe0 = fe_cnt;
      rx_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rx_i = 1'b1;
      repeat (2 * DIV) @(negedge clk_i);
      #2;
      n_cmp++; if (rise_cnt - rc0 !== 0 || fe_cnt - fe0 !== 0) begin n_bad++; $display("FAIL glitch_quiet: rises %0d ferr %0d want 0 0", rise_cnt - rc0, fe_cnt - fe0); end
      @(negedge clk_i);
      send_frame(8'h5A, 1'b1, s);
      repeat (3) @(negedge clk_i);
      #2;
      n_cmp++; if (rise_data !== 8'h5A || rise_edge - s !== LAT) begin n_bad++; $display("FAIL glitch_after: data %h lat %0d want 5a %0d", rise_data, rise_edge - s, LAT); end
      @(negedge clk_i);
   endtask

   task automatic test_reset_mid();
      int s, hs0, rc0;
      ready_i = 1'b1;
      hs0 = hs_q.size(); rc0 = rise_cnt;
      rx_i = 1'b0;
      repeat (DIV) @(negedge clk_i);
      rx_i = 1'b1;
      repeat (4 * DIV) @(negedge clk_i);
      rstn_i = 1'b0;
      repeat (3) @(negedge clk_i);
      rstn_i = 1'b1;
      repeat (5 * DIV + DIV) @(negedge clk_i);
      send_frame(8'h81, 1'b1, s);
      repeat (3) @(negedge clk_i);
      #2;
      n_cmp++; if (rise_cnt - rc0 !== 1) begin n_bad++; $display("FAIL rmid_count: got %0d want 1", rise_cnt - rc0); end
      n_cmp++; if (hs_q.size() - hs0 !== 1 || hs_q[$] !== 8'h81) begin n_bad++; $display("FAIL rmid_data: got %0d bytes last %h want 1 81", hs_q.size() - hs0, hs_q[$]); end
      n_cmp++; if (rise_edge - s !== LAT) begin n_bad++; $display("FAIL rmid_latency: got %0d want %0d", rise_edge - s, LAT); end
      @(negedge clk_i);
   endtask

   task automatic test_random();
      int s, gap;
      logic [7:0] b;
      logic [7:0] sent_q[$];
      int hs0;
      ready_i = 1'b1;
      hs0 = hs_q.size();
      for (int n = 0; n < 6; n++) begin
         b = 8'($urandom_range(0, 255));
         gap = $urandom_range(0, 3 * DIV);
         repeat (gap) @(negedge clk_i);
         sent_q.push_back(b);
         send_frame(b, 1'b1, s);
         repeat (2) @(negedge clk_i);
         #2;
         n_cmp++; if (rise_data !== b) begin n_bad++; $display("FAIL rand_data[%0d]: got %h want %h", n, rise_data, b); end
         n_cmp++; if (rise_edge - s !== LAT) begin n_bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, rise_edge - s, LAT); end
         @(negedge clk_i);
      end
      n_cmp++; if (hs_q.size() - hs0 !== sent_q.size()) begin n_bad++; $display("FAIL rand_stream: got %0d bytes want %0d", hs_q.size() - hs0, sent_q.size()); end
      else begin
         for (int n = 0; n < sent_q.size(); n++) begin
            n_cmp++; if (hs_q[hs0 + n] !== sent_q[n]) begin n_bad++; $display("FAIL rand_order[%0d]: got %h want %h", n, hs_q[hs0 + n], sent_q[n]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overrun();
      test_ready_coincide();
      test_frame_err();
      test_glitch();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
